seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
Parametrised multiplexed seven-segment display driver for the display subsystem. Rotates one active anode across NUM_DIGITS digits at a programmable refresh rate. Decodes each digit's 4-bit hex value to segments and applies a per-digit enable mask. Adds anti-ghosting dead time and frame-synchronous double-buffered data loading, and reports the active digit index.

Parameters:
NUM_DIGITS, 8, number of digits/anodes (legal 1..16)
REFRESH_DIV, 100000, clock cycles each digit slot lasts (legal >= 2)
BLANK_CYCLES, 2, cycles at start of each slot with all anodes inactive (legal 0..REFRESH_DIV-1)
ACTIVE_LOW, 1, 1 = anodes/segments/dp active-low, 0 = active-high
SEL_W, $clog2(NUM_DIGITS) min 1, width of digit index (derived, localparam)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
enable  input  1  0 = display dark, scan held at digit 0
data_in  input  4*NUM_DIGITS  hex nibble per digit; digit i = bits [4i+3:4i]
dp_in  input  NUM_DIGITS  decimal point per digit, 1 = lit
digit_en_in  input  NUM_DIGITS  per-digit enable, 0 = digit blanked
data_load  input  1  single-cycle strobe capturing data_in/dp_in/digit_en_in
an  output  NUM_DIGITS  anode drives, an[i] = digit i
seg  output  7  segments {g,f,e,d,c,b,a}
dp  output  1  decimal point drive
digit_sel  output  SEL_W  index of digit currently owning the slot
frame_done  output  1  one-cycle pulse when the last digit slot ends

Behaviour:
- Reset (rst=1 at clk edge): slot counter=0, index=0, pending and shadow registers=0, pending flag=0, frame_done=0, digit_sel=0, an/seg/dp = inactive level (all 1 when ACTIVE_LOW=1).
- Slot counter counts 0..REFRESH_DIV-1. At count REFRESH_DIV-1 it wraps to 0 and index advances. Index wraps NUM_DIGITS-1 -> 0.
- NUM_DIGITS=1: index stays 0; wrap still occurs every REFRESH_DIV cycles.
- frame_done=1 for exactly the cycle after the counter/index pair (REFRESH_DIV-1, NUM_DIGITS-1) is registered, aligned with index returning to 0.
- Outputs are registered, one cycle behind the counter/index state. Drive rules:
  - Counter < BLANK_CYCLES: all anodes inactive.
  - Else if shadow digit_en[index]=0: all anodes inactive.
  - Else: only an[index] active.
  - seg = decode(shadow nibble[index]); dp = shadow dp[index]. Both are forced inactive whenever the anodes are inactive.
- digit_sel = registered index, updated with the same one-cycle latency. Blank and disabled slots still occupy full slot time, so brightness is uniform.
- Decode (active-high form, inverted when ACTIVE_LOW): standard hex 0-9, A, b, C, d, E, F.
- Double buffering:
  - data_load copies the inputs into the pending registers and sets the pending flag. Multiple loads before a boundary: last wins.
  - At the frame boundary (index wrap to 0), if the pending flag is set, shadow <= pending and the flag clears.
  - data_load in the same cycle as the boundary writes the inputs straight into shadow and leaves the flag clear.
  - Shadow never changes mid-frame.
  - First load after reset or while enable=0: shadow updates immediately on load, since the display is dark.
- enable=0: counter and index are forced to 0, outputs inactive, frame_done=0, pending logic still accepts loads. On enable rising, scan restarts at digit 0, counter 0, with BLANK_CYCLES of dead time first.
- rst mid-frame returns everything to reset values on the next edge. rst has priority over enable and data_load.

Decomposition:
- Package seven_seg_pkg: segment bit-index constants, 7-bit active-high hex segment encoding constants, SEG_OFF constant, hex_to_seg function.
- Sub-module hex_to_seg7: combinational nibble -> 7-bit active-high segments, with polarity applied in the top level.
- Top level holds the counter, index, buffers and output registers.

Test Plan:
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, ACTIVE_LOW=1 unless noted.
- Reset then enable=1: an cycles 1111,1110,1110,1110,1111,1101,... (each digit active 3 of 4 cycles). frame_done pulses every 16 cycles. digit_sel sequence 0,1,2,3,0.
- Load data_in=16'h3A5F, digit_en_in=4'b1111 with enable=0, then enable=1: digit0 slot gives seg=F pattern (7'b0001110); digit1 5 (0010010); digit2 A (0001000); digit3 3 (0110000).
- Mid-frame load of 16'h0000 during digit1 slot: digits 1-3 keep old values until frame_done. Next frame shows 0 (1000000) on all digits.
- digit_en_in=4'b0101: an never activates digits 1 and 3. Their slots still last 4 cycles, with seg/dp inactive.
- data_load coincident with the boundary cycle: new value visible in the digit0 slot immediately. Assert rst mid-slot: next cycle an=1111, digit_sel=0, frame_done=0.
- NUM_DIGITS=1, REFRESH_DIV=2, BLANK_CYCLES=0: an[0] constantly active. frame_done pulses every 2 cycles.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: segment bit positions, active-high hex glyphs and the nibble-to-glyph decode
package seven_seg_pkg;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [6:0] SEG_HEX_0 = 7'h3f;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5b;
  localparam logic [6:0] SEG_HEX_3 = 7'h4f;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6d;
  localparam logic [6:0] SEG_HEX_6 = 7'h7d;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7f;
  localparam logic [6:0] SEG_HEX_9 = 7'h6f;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7c;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5e;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    unique case (hex)
      4'h0: return SEG_HEX_0;
      4'h1: return SEG_HEX_1;
      4'h2: return SEG_HEX_2;
      4'h3: return SEG_HEX_3;
      4'h4: return SEG_HEX_4;
      4'h5: return SEG_HEX_5;
      4'h6: return SEG_HEX_6;
      4'h7: return SEG_HEX_7;
      4'h8: return SEG_HEX_8;
      4'h9: return SEG_HEX_9;
      4'ha: return SEG_HEX_A;
      4'hb: return SEG_HEX_B;
      4'hc: return SEG_HEX_C;
      4'hd: return SEG_HEX_D;
      4'he: return SEG_HEX_E;
      default: return SEG_HEX_F;
    endcase
  endfunction
endpackage

// File: rtl/seven_seg_scanner_hex_to_seg7.sv
// hex_to_seg7: combinational nibble to active-high {g,f,e,d,c,b,a} segments
module hex_to_seg7
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  assign seg_o = hex_to_seg(hex_i);
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed seven-segment driver with dead time and frame-synchronous double buffering
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2,
  parameter bit ACTIVE_LOW   = 1'b1,
  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en_in,
  input  logic                    data_load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [SEL_W-1:0]        digit_sel,
  output logic                    frame_done
);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0] SEG_IDLE = SEG_OFF ^ {7{ACTIVE_LOW}};
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] idx_q, idx_d, sel_q;
  logic [4*NUM_DIGITS-1:0] sh_data_q, pend_data_q;
  logic [NUM_DIGITS-1:0] sh_dp_q, sh_en_q, pend_dp_q, pend_en_q, an_q, an_d;
  logic [6:0] seg_q, seg_d, glyph;
  logic dp_q, dp_d, fd_q, pend_q, loaded_q;
  logic last_cnt, wrap, direct, active;
  hex_to_seg7 u_dec (.hex_i(sh_data_q[{idx_q, 2'b00} +: 4]), .seg_o(glyph));
  always_comb begin
    last_cnt = cnt_q == CNT_W'(REFRESH_DIV - 1);
    wrap     = enable && last_cnt && idx_q == SEL_W'(NUM_DIGITS - 1);
    direct   = data_load && (wrap || !enable || !loaded_q);
    cnt_d    = (!enable || last_cnt) ? '0 : cnt_q + 1'b1;
    idx_d    = (!enable || wrap) ? '0 : idx_q + SEL_W'(last_cnt);
    active   = enable && cnt_q >= CNT_W'(BLANK_CYCLES) && sh_en_q[idx_q];
    an_d     = AN_OFF ^ (active ? NUM_DIGITS'(1) << idx_q : '0);
    seg_d    = {7{ACTIVE_LOW}} ^ (active ? glyph : SEG_OFF);
    dp_d     = ACTIVE_LOW ^ (active && sh_dp_q[idx_q]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      sel_q       <= '0;
      fd_q        <= 1'b0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_IDLE;
      dp_q        <= ACTIVE_LOW;
      sh_data_q   <= '0;
      sh_dp_q     <= '0;
      sh_en_q     <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_en_q   <= '0;
      pend_q      <= 1'b0;
      loaded_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sel_q    <= idx_q;
      fd_q     <= wrap;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      loaded_q <= loaded_q | data_load;
      pend_q   <= data_load ? !direct : (pend_q && !wrap);
      if (data_load) begin
        pend_data_q <= data_in;
        pend_dp_q   <= dp_in;
        pend_en_q   <= digit_en_in;
      end
      if (direct) begin
        sh_data_q <= data_in;
        sh_dp_q   <= dp_in;
        sh_en_q   <= digit_en_in;
      end else if (wrap && pend_q) begin
        sh_data_q <= pend_data_q;
        sh_dp_q   <= pend_dp_q;
        sh_en_q   <= pend_en_q;
      end
    end
  end
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_sel  = sel_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: time-based reference model plus directed scenarios with literal expectations
module tb_seven_seg_scanner;
  localparam int N = 4;
  localparam int R = 4;
  localparam int B = 1;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, data_load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0] dp_in = '0, digit_en_in = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp, frame_done;
  logic [1:0] digit_sel;
  logic an1, dp1, sel1, fd1;
  logic [6:0] seg1;
  int checks = 0, errors = 0;
  bit chk_on = 0;
  always #5 clk = ~clk;
  seven_seg_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .data_in(data_in), .dp_in(dp_in),
    .digit_en_in(digit_en_in), .data_load(data_load), .an(an), .seg(seg), .dp(dp),
    .digit_sel(digit_sel), .frame_done(frame_done));
  seven_seg_scanner #(.NUM_DIGITS(1), .REFRESH_DIV(2), .BLANK_CYCLES(0), .ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .data_in(data_in[3:0]), .dp_in(dp_in[0]),
    .digit_en_in(digit_en_in[0]), .data_load(data_load), .an(an1), .seg(seg1), .dp(dp1),
    .digit_sel(sel1), .frame_done(fd1));
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask
  logic [6:0] hex_tab [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                              7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};
  logic [15:0] m_data, p_data;
  logic [3:0] m_dp, m_en, p_dp, p_en, e_an;
  logic [6:0] e_seg;
  logic [1:0] e_sel;
  logic e_dp, e_fd;
  bit pf, ld;
  int t;
  always @(posedge clk) begin
    int dg, off;
    bit wrap, act;
    off  = t % R;
    dg   = (t / R) % N;
    wrap = enable && off == R - 1 && dg == N - 1;
    act  = enable && off >= B && m_en[dg];
    if (rst) begin
      t = 0; pf = 0; ld = 0;
      m_data = '0; m_dp = '0; m_en = '0; p_data = '0; p_dp = '0; p_en = '0;
      e_an = 4'hf; e_seg = 7'h7f; e_dp = 1'b1; e_sel = '0; e_fd = 1'b0;
    end else begin
      e_an  = act ? ~(4'b1 << dg) : 4'hf;
      e_seg = act ? ~hex_tab[m_data[4*dg +: 4]] : 7'h7f;
      e_dp  = act ? ~m_dp[dg] : 1'b1;
      e_sel = 2'(dg);
      e_fd  = wrap;
      if (data_load && (wrap || !enable || !ld)) begin
        m_data = data_in; m_dp = dp_in; m_en = digit_en_in; pf = 0;
      end else begin
        if (wrap && pf) begin
          m_data = p_data; m_dp = p_dp; m_en = p_en; pf = 0;
        end
        if (data_load) begin
          p_data = data_in; p_dp = dp_in; p_en = digit_en_in; pf = 1;
        end
      end
      if (data_load) ld = 1;
      t = enable ? t + 1 : 0;
    end
  end
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_an", 32'(an), 32'(e_an));
      chk("model_seg", 32'(seg), 32'(e_seg));
      chk("model_dp", 32'(dp), 32'(e_dp));
      chk("model_sel", 32'(digit_sel), 32'(e_sel));
      chk("model_fd", 32'(frame_done), 32'(e_fd));
    end
  end
  task automatic wait_an(input logic [3:0] w, input string n);
    int k = 0;
    do begin @(negedge clk); k++; end while (an !== w && k < 64);
    if (an !== w) chk(n, 32'(an), 32'(w));
  endtask
  task automatic wait_fd(input string n);
    int k = 0;
    do begin @(negedge clk); k++; end while (frame_done !== 1'b1 && k < 40);
    if (frame_done !== 1'b1) chk(n, 32'(frame_done), 32'd1);
  endtask
  task automatic load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
    data_in = d; dp_in = p; digit_en_in = e; data_load = 1'b1;
    @(negedge clk);
    data_load = 1'b0;
  endtask
  initial begin
    logic [3:0] an_seq [5] = '{4'hf, 4'he, 4'he, 4'he, 4'hf};
    int k, bad, on0;
    logic prev;
    @(negedge clk);
    chk_on = 1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_an", 32'(an), 32'hf);
    chk("rst_sel", 32'(digit_sel), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_seg", 32'(seg), 32'h7f);
    load(16'h3A5F, 4'b0010, 4'hf);
    enable = 1'b1;
    wait_an(4'b1110, "wait_d0");
    chk("seg_F", 32'(seg), 32'(7'b0001110));
    chk("dp_d0_off", 32'(dp), 32'd1);
    wait_an(4'b1101, "wait_d1");
    chk("seg_5", 32'(seg), 32'(7'b0010010));
    chk("dp_d1_on", 32'(dp), 32'd0);
    wait_an(4'b1011, "wait_d2");
    chk("seg_A", 32'(seg), 32'(7'b0001000));
    wait_an(4'b0111, "wait_d3");
    chk("seg_3", 32'(seg), 32'(7'b0110000));
    wait_fd("wait_fd0");
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k <= 5) chk("an_seq", 32'(an), 32'(an_seq[k-1]));
    end while (frame_done !== 1'b1 && k < 40);
    chk("fd_period", 32'(k), 32'd16);
    wait_an(4'b1101, "wait_mid");
    load(16'h0000, 4'b0000, 4'hf);
    wait_an(4'b1011, "wait_old2");
    chk("old_seg_A", 32'(seg), 32'(7'b0001000));
    wait_an(4'b0111, "wait_old3");
    chk("old_seg_3", 32'(seg), 32'(7'b0110000));
    wait_an(4'b1110, "wait_new0");
    chk("new_seg0", 32'(seg), 32'(7'b1000000));
    wait_an(4'b1101, "wait_new1");
    chk("new_seg1", 32'(seg), 32'(7'b1000000));
    chk("new_dp1", 32'(dp), 32'd1);
    prev = fd1;
    repeat (6) begin
      @(negedge clk);
      chk("n1_an", 32'(an1), 32'd0);
      chk("n1_fd_toggle", 32'(fd1), 32'(!prev));
      prev = fd1;
    end
    wait_fd("wait_fd1");
    load(16'h1234, 4'b0000, 4'b0101);
    wait_fd("wait_fd2");
    bad = 0; on0 = 0;
    repeat (16) begin
      @(negedge clk);
      if (an[1] === 1'b0 || an[3] === 1'b0) bad++;
      if (an === 4'b1110) on0++;
    end
    chk("mask_off", 32'(bad), 32'd0);
    chk("mask_d0_cycles", 32'(on0), 32'd3);
    wait_fd("wait_fd3");
    repeat (15) @(negedge clk);
    load(16'h0007, 4'b0000, 4'hf);
    chk("coinc_fd", 32'(frame_done), 32'd1);
    wait_an(4'b1110, "wait_coinc0");
    chk("coinc_seg7", 32'(seg), 32'(7'b1111000));
    wait_an(4'b1101, "wait_coinc1");
    chk("coinc_seg0", 32'(seg), 32'(7'b1000000));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_an", 32'(an), 32'hf);
    chk("mrst_sel", 32'(digit_sel), 32'd0);
    chk("mrst_fd", 32'(frame_done), 32'd0);
    load(16'hBCDE, 4'b0000, 4'hf);
    wait_an(4'b1110, "wait_first");
    chk("first_seg_E", 32'(seg), 32'(7'b0000110));
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk("dis_an", 32'(an), 32'hf);
    chk("dis_sel", 32'(digit_sel), 32'd0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end
endmodule
